// File: rtl/ysyx_22050612_defs.sv
// Shared definitions for the instruction-memory responder: default base address,
// FSM state encoding and the word returned on a faulting fetch.
package ysyx_22050612_defs;

    localparam logic [63:0] IMEM_BASE = 64'h8000_0000;
    localparam logic [31:0] INST_ERR  = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ysyx_22050612_imem_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read, contents survive reset.
// Latency: write visible to reads the cycle after; no backpressure.
module ysyx_22050612_imem_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ysyx_22050612_imem_resp.sv
// Instruction fetch responder: word-addressed store behind valid/ready request and response channels.
// Latency: LATENCY cycles from request accept to resp_valid; one request outstanding, req_ready drops while busy.
module ysyx_22050612_imem_resp
    import ysyx_22050612_defs::*;
#(
    parameter logic [63:0] BASE    = IMEM_BASE,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_inst,
    output logic                     resp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data,
    output logic [31:0]              fetch_cnt
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [63:0] SPAN       = 64'(DEPTH) << 2;
    localparam logic [3:0]  LAT_RELOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t        state;
    logic [3:0]    lat_cnt;
    logic [AW-1:0] pend_idx;
    logic          pend_err;

    logic [63:0]   off;
    logic          dec_err;
    logic [AW-1:0] dec_idx;
    logic          req_fire;
    logic          resp_fire;
    logic          wait_done;
    logic [AW-1:0] rd_idx;
    logic          rd_err;
    logic [31:0]   rd_word;
    logic [31:0]   cap_word;

    // Offset is unsigned at full width, so addresses below BASE wrap high and also fail the span test.
    assign off     = req_addr - BASE;
    assign dec_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (off >= SPAN);
    assign dec_idx = off[AW+1:2];

    assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
    assign req_fire  = req_valid && req_ready;
    assign resp_fire = resp_valid && resp_ready;
    assign wait_done = (state == WAIT) && (lat_cnt == 4'd0);

    // The read happens on the cycle that moves into RESP: either the accepting cycle or the last WAIT cycle.
    always_comb begin
        rd_idx   = wait_done ? pend_idx : dec_idx;
        rd_err   = wait_done ? pend_err : dec_err;
        cap_word = INST_ERR;
        if (!rd_err) begin
            cap_word = (ld_en && (ld_idx == rd_idx)) ? ld_data : rd_word;
        end
    end

    ysyx_22050612_imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ld_en),
        .widx  (ld_idx),
        .wdata (ld_data),
        .ridx  (rd_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            pend_idx   <= '0;
            pend_err   <= 1'b0;
            resp_valid <= 1'b0;
            resp_inst  <= INST_ERR;
            resp_err   <= 1'b0;
            fetch_cnt  <= 32'd0;
        end else begin
            if (resp_fire) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            case (state)
                WAIT: begin
                    if (wait_done) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_inst  <= cap_word;
                        resp_err   <= rd_err;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                IDLE, RESP: begin
                    if (req_fire) begin
                        pend_idx <= dec_idx;
                        pend_err <= dec_err;
                        if (LATENCY > 1) begin
                            state      <= WAIT;
                            lat_cnt    <= LAT_RELOAD;
                            resp_valid <= 1'b0;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_inst  <= cap_word;
                            resp_err   <= rd_err;
                        end
                    end else if (resp_fire) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
